// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner encodings and access-size codes for mem_arbiter
package mem_arb_pkg;
    typedef enum logic {IDLE, WAIT_RD} state_t;
    typedef enum logic {OWN_CORE, OWN_DBG} owner_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/mem_arb_align_chk.sv
// mem_arb_align_chk: flags halfword/word accesses that straddle their natural boundary
module mem_arb_align_chk
    import mem_arb_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] adr_lsb,
    output logic       misalign
);
    assign misalign = ((funct3 == F3_H || funct3 == F3_HU) && adr_lsb[0]) ||
                      (funct3 == F3_W && adr_lsb != 2'b00);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: core vs debug/loader arbiter onto one unified memory port.
// Define MEM_ARB_ALIGN_CHECK_EN to suppress and flag misaligned halfword/word accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY   = 1,
    parameter int DBG_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic [31:0] core_adr,
    input  logic        core_we,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic        core_gnt,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    input  logic        dbg_req,
    input  logic [31:0] dbg_adr,
    input  logic        dbg_we,
    input  logic [31:0] dbg_wdata,
    input  logic [2:0]  dbg_funct3,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rvalid,
    output logic [31:0] mem_adr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata,
    output logic        misalign_err
);
    localparam logic [3:0] BMAX = 4'(DBG_BURST_MAX);
    localparam logic [2:0] LAT  = 3'(MEM_LATENCY);
    state_t      state;
    owner_t      owner;
    logic [3:0]  streak;
    logic [2:0]  lat;
    logic [31:0] rdata_q;
    logic        bad_q;
    logic        idle, any_gnt, sel_we, rd_gnt, misalign, rvalid;
    logic [31:0] rdata_now;
    // Gating with reset keeps every grant low while reset is held.
    assign idle     = reset && state == IDLE;
    assign dbg_gnt  = idle && dbg_req && !(core_req && streak == BMAX);
    assign core_gnt = idle && core_req && !dbg_gnt;
    assign any_gnt  = core_gnt || dbg_gnt;
    assign mem_adr    = dbg_gnt ? dbg_adr : core_adr;
    assign mem_wdata  = dbg_gnt ? dbg_wdata : core_wdata;
    assign mem_funct3 = dbg_gnt ? dbg_funct3 : core_funct3;
    assign sel_we     = dbg_gnt ? dbg_we : core_we;
    assign mem_we     = any_gnt && sel_we && !misalign;
    assign rd_gnt     = any_gnt && !sel_we;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic misalign_raw;
    mem_arb_align_chk u_align (
        .funct3  (mem_funct3),
        .adr_lsb (mem_adr[1:0]),
        .misalign(misalign_raw)
    );
    assign misalign = any_gnt && misalign_raw;
`else
    assign misalign = 1'b0;
`endif
    assign misalign_err = misalign;
    assign rvalid      = state == WAIT_RD && lat == LAT;
    assign rdata_now   = bad_q ? '0 : mem_rdata;
    assign core_rvalid = rvalid && owner == OWN_CORE;
    assign dbg_rvalid  = rvalid && owner == OWN_DBG;
    assign core_rdata  = owner != OWN_CORE ? '0 : core_rvalid ? rdata_now : rdata_q;
    assign dbg_rdata   = owner != OWN_DBG ? '0 : dbg_rvalid ? rdata_now : rdata_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= OWN_CORE;
            streak  <= '0;
            lat     <= '0;
            rdata_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            streak <= (!core_req || core_gnt) ? '0 :
                      (dbg_gnt && streak != BMAX) ? streak + 4'd1 : streak;
            if (rd_gnt) begin
                state <= WAIT_RD;
                owner <= dbg_gnt ? OWN_DBG : OWN_CORE;
                lat   <= 3'd1;
                bad_q <= misalign;
                // A new owner starts from 0 since it showed 0 as the non-owner.
                if (dbg_gnt != (owner == OWN_DBG))
                    rdata_q <= '0;
            end else if (rvalid) begin
                state   <= IDLE;
                rdata_q <= rdata_now;
            end else if (state == WAIT_RD) begin
                lat <= lat + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a rule-level model
module tb_mem_arbiter;
    localparam int LAT  = 3;
    localparam int BMAX = 4;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif
    logic        clk = 1'b0, reset;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, mem_we, misalign_err;
    logic [31:0] core_adr, core_wdata, core_rdata, dbg_adr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [2:0]  core_funct3, dbg_funct3, mem_funct3;
    typedef struct {logic own; int cyc; logic [31:0] data;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] rd_sched[int];
    int          cyc = 0, vec = 0, err = 0, busy_until = -1, streak = 0;
    logic        cur_owner = 1'b0, own_prev = 1'b0;
    logic [31:0] pc = '0, pd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.MEM_LATENCY(LAT), .DBG_BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_adr(core_adr), .core_we(core_we), .core_wdata(core_wdata),
        .core_funct3(core_funct3), .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
        .dbg_funct3(dbg_funct3), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .misalign_err(misalign_err)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    function automatic logic mis_f(input logic [2:0] f, input logic [31:0] a);
        int sz;
        sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        return ACHK && (a % sz != 0);
    endfunction

    task automatic rand_req(input bit wr_only, output logic req, output logic we,
                            output logic [31:0] adr, output logic [31:0] wd, output logic [2:0] f3);
        int i;
        i   = $urandom_range(0, 4);
        f3  = (i < 3) ? 3'(i) : 3'(i + 1);
        req = wr_only || ($urandom_range(0, 3) != 0);
        we  = wr_only || ($urandom_range(0, 1) == 1);
        adr = 32'h1000 + 32'($urandom_range(0, 7) * 4) +
              (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        wd  = $urandom;
    endtask

    task automatic step(input bit wr_only);
        logic cg, dg;
        @(negedge clk);
        cg = core_gnt;
        dg = dbg_gnt;
        @(posedge clk);
        #1;
        if (!core_req || cg) rand_req(wr_only, core_req, core_we, core_adr, core_wdata, core_funct3);
        if (!dbg_req || dg) rand_req(wr_only, dbg_req, dbg_we, dbg_adr, dbg_wdata, dbg_funct3);
    endtask

    // memory model: returns the reference word LAT cycles after a read grant, garbage otherwise
    always @(posedge clk) begin
        #1;
        mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
    end

    // stimulus-side model: arbitration rules, memory-port checks, pushes expected read returns
    always @(negedge clk) begin
        logic ed, ec, sw, mis;
        logic [31:0] sa, swd;
        logic [2:0] sf;
        if (!reset) begin
            chk("rst_core_gnt", core_gnt, 0);
            chk("rst_dbg_gnt", dbg_gnt, 0);
            chk("rst_core_rvalid", core_rvalid, 0);
            chk("rst_dbg_rvalid", dbg_rvalid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_misalign", misalign_err, 0);
            chk("rst_core_rdata", core_rdata, 0);
            chk("rst_dbg_rdata", dbg_rdata, 0);
            busy_until = -1;
            streak = 0;
            cur_owner = 1'b0;
            exp_q.delete();
            rd_sched.delete();
        end else begin
            ed = cyc > busy_until && dbg_req && !(core_req && streak == BMAX);
            ec = cyc > busy_until && core_req && !ed;
            chk("core_gnt", core_gnt, ec);
            chk("dbg_gnt", dbg_gnt, ed);
            if (ec || ed) begin
                sa  = ed ? dbg_adr : core_adr;
                sw  = ed ? dbg_we : core_we;
                swd = ed ? dbg_wdata : core_wdata;
                sf  = ed ? dbg_funct3 : core_funct3;
                mis = mis_f(sf, sa);
                chk("mem_adr", mem_adr, sa);
                chk("mem_funct3", mem_funct3, sf);
                chk("mem_we", mem_we, sw && !mis);
                chk("misalign_err", misalign_err, mis);
                if (sw && !mis) begin
                    chk("mem_wdata", mem_wdata, swd);
                    ref_mem[sa] = swd;
                end
                if (!sw) begin
                    rd_sched[cyc + LAT] = rd_val(sa);
                    exp_q.push_back(exp_t'{ed, cyc + LAT, mis ? 32'h0 : rd_val(sa)});
                    busy_until = cyc + LAT;
                    cur_owner = ed;
                end
            end else begin
                chk("idle_mem_we", mem_we, 0);
                chk("idle_misalign", misalign_err, 0);
            end
            streak = (!core_req || ec) ? 0 : (ed && streak < BMAX) ? streak + 1 : streak;
        end
    end

    // monitor: pops the scoreboard whenever the DUT returns read data
    always @(negedge clk) begin
        exp_t e;
        logic ecv, edv;
        logic [31:0] d, ecr, edr;
        #1;
        if (!reset) begin
            own_prev = 1'b0;
            pc = '0;
            pd = '0;
        end else begin
            ecv = 1'b0;
            edv = 1'b0;
            d = '0;
            if (core_rvalid || dbg_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rvalid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    ecv = !e.own;
                    edv = e.own;
                    d = e.data;
                    chk("rvalid_cycle", cyc, e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("rvalid_missing", 0, 1);
            end
            chk("core_rvalid", core_rvalid, ecv);
            chk("dbg_rvalid", dbg_rvalid, edv);
            ecr = ecv ? d : (own_prev == 1'b0 ? pc : 32'h0);
            edr = edv ? d : (own_prev == 1'b1 ? pd : 32'h0);
            chk("core_rdata", core_rdata, ecr);
            chk("dbg_rdata", dbg_rdata, edr);
            pc = ecr;
            pd = edr;
            own_prev = cur_owner;
        end
    end

    initial begin
        int n;
        logic g;
        reset = 1'b1;
        core_req = 0; core_we = 0; core_adr = 0; core_wdata = 0; core_funct3 = 3'b010;
        dbg_req = 0; dbg_we = 0; dbg_adr = 0; dbg_wdata = 0; dbg_funct3 = 3'b010;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        rand_req(1, core_req, core_we, core_adr, core_wdata, core_funct3);
        rand_req(1, dbg_req, dbg_we, dbg_adr, dbg_wdata, dbg_funct3);
        repeat (20) step(1);
        repeat (400) step(0);
        dbg_req = 0;
        core_req = 1; core_we = 0; core_adr = 32'h10; core_funct3 = 3'b010;
        n = 0;
        do begin
            @(negedge clk);
            g = core_gnt;
            n++;
        end while (!g && n < 20);
        chk("rd_gnt_before_reset", g, 1);
        @(posedge clk);
        #1;
        core_req = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        repeat (300) step(0);
        core_req = 0;
        dbg_req = 0;
        repeat (10) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
